// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: FunSel opcodes and width-generic next-state helpers for the register bank.
// Helpers work on MAX_W-bit words; callers pass their real width and truncate the result.
package reg_bank_pkg;

    localparam logic [2:0] FS_DEC       = 3'b000;
    localparam logic [2:0] FS_INC       = 3'b001;
    localparam logic [2:0] FS_LOAD      = 3'b010;
    localparam logic [2:0] FS_CLR       = 3'b011;
    localparam logic [2:0] FS_LDL_CLRH  = 3'b100;
    localparam logic [2:0] FS_LDL_KEEPH = 3'b101;
    localparam logic [2:0] FS_LDH_KEEPL = 3'b110;
    localparam logic [2:0] FS_LDL_SEXT  = 3'b111;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t width_mask(input int w);
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t next_q(input logic [2:0] op, input word_t q, input word_t i, input int w);
        word_t mask;
        word_t lo;
        word_t hi;
        int half;
        half = w / 2;
        mask = width_mask(w);
        lo   = width_mask(half);
        hi   = mask & ~lo;
        case (op)
            FS_DEC:       next_q = (q - word_t'(1)) & mask;
            FS_INC:       next_q = (q + word_t'(1)) & mask;
            FS_LOAD:      next_q = i & mask;
            FS_CLR:       next_q = '0;
            FS_LDL_CLRH:  next_q = i & lo;
            FS_LDL_KEEPH: next_q = (q & hi) | (i & lo);
            FS_LDH_KEEPL: next_q = ((i & lo) << half) | (q & lo);
            default:      next_q = (i & lo) | (i[half-1] ? hi : '0);
        endcase
    endfunction

    function automatic logic wraps(input logic [2:0] op, input word_t q, input int w);
        return (op == FS_INC && q == width_mask(w)) || (op == FS_DEC && q == '0);
    endfunction

    // Whole-register and low-half-with-defined-high loads restart overflow tracking.
    function automatic logic clears_wrap(input logic [2:0] op);
        return op == FS_LOAD || op == FS_CLR || op == FS_LDL_CLRH || op == FS_LDL_SEXT;
    endfunction

endpackage

// File: rtl/reg_fs_cell.sv
// reg_fs_cell: one FunSel register with sticky wrap flag; NextQ is the value it will hold after the next edge.
module reg_fs_cell
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap,
    output logic [WIDTH-1:0] NextQ
);

    logic [WIDTH-1:0] op_q;
    logic             op_wrap;

    always_comb begin
        op_q    = WIDTH'(next_q(FunSel, word_t'(Q), word_t'(I), WIDTH));
        op_wrap = wraps(FunSel, word_t'(Q), WIDTH) ? 1'b1 : clears_wrap(FunSel) ? 1'b0 : Wrap;
        NextQ   = Reset ? RESET_VAL : E ? op_q : Q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q    <= RESET_VAL;
            Wrap <= 1'b0;
        end else if (E) begin
            Q    <= op_q;
            Wrap <= op_wrap;
        end
    end

endmodule

// File: rtl/reg_bank_fs.sv
// reg_bank_fs: bank of NUM_REGS FunSel registers with two combinational read ports and sticky wrap flags.
// Define REG_BANK_FS_BYPASS_EN to forward each register's next-state value onto the read ports.
module reg_bank_fs
    import reg_bank_pkg::*;
#(
    parameter  int               WIDTH     = 16,
    parameter  int               NUM_REGS  = 4,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [2:0]          FunSel,
    input  logic [WIDTH-1:0]    I,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic [NUM_REGS-1:0] Wrap
);

`ifdef REG_BANK_FS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Read table padded to a power of two so unused selects read zero.
    localparam int PAD = 1 << SEL_W;

    logic [WIDTH-1:0] q  [NUM_REGS];
    logic [WIDTH-1:0] nq [NUM_REGS];
    logic [WIDTH-1:0] rd [PAD];

    for (genvar k = 0; k < PAD; k++) begin : g_reg
        if (k < NUM_REGS) begin : g_cell
            reg_fs_cell #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL)
            ) u_cell (
                .Clock (Clock),
                .Reset (Reset),
                .E     (RegSel[k]),
                .FunSel(FunSel),
                .I     (I),
                .Q     (q[k]),
                .Wrap  (Wrap[k]),
                .NextQ (nq[k])
            );
            assign rd[k] = BYPASS ? nq[k] : q[k];
        end else begin : g_pad
            assign rd[k] = '0;
        end
    end

    assign OutA = rd[OutASel];
    assign OutB = rd[OutBSel];

endmodule

// File: tb/tb_reg_bank_fs.sv
// tb_reg_bank_fs: directed-vector bench with a per-register behavioural model checked every cycle.
module tb_reg_bank_fs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  reg_sel;
    logic [2:0]  fs;
    logic [15:0] din;
    logic [1:0]  asel, bsel;
    logic [15:0] out_a, out_b, out_a2, out_b2;
    logic [3:0]  wrap, wrap2;

    int checks = 0;
    int errors = 0;
    bit active = 1'b0;
    logic [1:0] cyc = 2'd0;

    localparam logic [15:0] RV = 16'h0000;
    logic [15:0] m [4];
    logic [3:0]  mw;

    reg_bank_fs dut (
        .Clock(clk), .Reset(reset), .RegSel(reg_sel), .FunSel(fs), .I(din),
        .OutASel(asel), .OutBSel(bsel), .OutA(out_a), .OutB(out_b), .Wrap(wrap)
    );

    reg_bank_fs #(.RESET_VAL(16'h00FF)) dut_ff (
        .Clock(clk), .Reset(reset), .RegSel(reg_sel), .FunSel(fs), .I(din),
        .OutASel(asel), .OutBSel(bsel), .OutA(out_a2), .OutB(out_b2), .Wrap(wrap2)
    );

    function automatic logic [15:0] mop(input logic [2:0] op, input logic [15:0] q, input logic [15:0] d);
        case (op)
            3'd0: return q - 16'd1;
            3'd1: return q + 16'd1;
            3'd2: return d;
            3'd3: return 16'h0000;
            3'd4: return {8'h00, d[7:0]};
            3'd5: return {q[15:8], d[7:0]};
            3'd6: return {d[7:0], q[7:0]};
            default: return {{8{d[7]}}, d[7:0]};
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input logic [1:0] s);
`ifdef REG_BANK_FS_BYPASS_EN
        if (reset) return RV;
        if (reg_sel[s]) return mop(fs, m[s], din);
`endif
        return m[s];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            chk("outa", 32'(out_a), 32'(exp_out(asel)));
            chk("outb", 32'(out_b), 32'(exp_out(bsel)));
            chk("wrap", 32'(wrap), 32'(mw));
        end
    end

    task automatic step(input logic r, input logic [3:0] rs, input logic [2:0] f, input logic [15:0] d);
        reset = r; reg_sel = rs; fs = f; din = d;
        asel = cyc; bsel = cyc + 2'd1; cyc = cyc + 2'd1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                m[k] = RV;
                mw[k] = 1'b0;
            end else if (rs[k]) begin
                if ((f == 3'd1 && m[k] == 16'hFFFF) || (f == 3'd0 && m[k] == 16'h0000)) mw[k] = 1'b1;
                else if (f == 3'd2 || f == 3'd3 || f == 3'd4 || f == 3'd7) mw[k] = 1'b0;
                m[k] = mop(f, m[k], d);
            end
        end
        #1;
        reset = 1'b0; reg_sel = 4'd0;
    endtask

    task automatic lit(input string name, input int s, input logic [15:0] e);
        asel = 2'(s); bsel = 2'(s);
        #1;
        chk(name, 32'(out_a), 32'(e));
        chk({name, "_b"}, 32'(out_b), 32'(e));
    endtask

    initial begin
        reset = 1'b1; reg_sel = 4'd0; fs = 3'd0; din = 16'd0; asel = 2'd0; bsel = 2'd0; mw = 4'd0;
        for (int k = 0; k < 4; k++) m[k] = 16'hxxxx;
        step(1'b1, 4'd0, 3'd0, 16'd0);
        active = 1'b1;
        for (int s = 0; s < 4; s++) begin
            lit("reset_q", s, 16'h0000);
            chk("reset_q_ff", 32'(out_a2), 32'h00FF);
        end
        chk("reset_wrap", 32'(wrap), 32'h0);
        step(1'b0, 4'b0001, 3'd2, 16'hABCD); lit("r0_load", 0, 16'hABCD);
        step(1'b0, 4'b0001, 3'd6, 16'h0012); lit("r0_ldh", 0, 16'h12CD);
        step(1'b0, 4'b0001, 3'd4, 16'hFF34); lit("r0_ldl_clrh", 0, 16'h0034);
        step(1'b0, 4'b0010, 3'd7, 16'h0080); lit("r1_sext_neg", 1, 16'hFF80);
        step(1'b0, 4'b0010, 3'd7, 16'h007F); lit("r1_sext_pos", 1, 16'h007F);
        step(1'b0, 4'b0010, 3'd5, 16'h0099); lit("r1_keeph", 1, 16'h0099);
        step(1'b0, 4'b0100, 3'd2, 16'hFFFF);
        step(1'b0, 4'b0100, 3'd1, 16'h0000); lit("r2_inc_wrap", 2, 16'h0000);
        chk("wrap_inc", 32'(wrap), 32'h4);
        step(1'b0, 4'b0100, 3'd0, 16'h0000); lit("r2_dec_wrap", 2, 16'hFFFF);
        chk("wrap_sticky", 32'(wrap), 32'h4);
        step(1'b0, 4'b0100, 3'd3, 16'h0000); lit("r2_clr", 2, 16'h0000);
        chk("wrap_clr", 32'(wrap), 32'h0);
        step(1'b0, 4'b0100, 3'd0, 16'h0000); lit("r2_dec_again", 2, 16'hFFFF);
        chk("wrap_dec", 32'(wrap), 32'h4);
        for (int k = 0; k < 4; k++) step(1'b0, 4'(1 << k), 3'd2, 16'(k + 1));
        step(1'b0, 4'b1111, 3'd1, 16'h0000);
        lit("multi_inc_r0", 0, 16'h0002);
        lit("multi_inc_r3", 3, 16'h0005);
        chk("wrap_after_load", 32'(wrap), 32'h0);
        for (int n = 0; n < 3; n++) step(1'b0, 4'b0000, 3'd1, 16'hFFFF);
        lit("idle_r1", 1, 16'h0003);
        lit("idle_r2", 2, 16'h0004);
        step(1'b0, 4'b0001, 3'd2, 16'hFFFF);
        step(1'b0, 4'b0010, 3'd2, 16'hFFFF);
        step(1'b0, 4'b0011, 3'd1, 16'h0000);
        chk("wrap_multi", 32'(wrap), 32'h3);
        step(1'b0, 4'b1111, 3'd0, 16'h0000);
        lit("multi_dec_r0", 0, 16'hFFFF);
        lit("multi_dec_r3", 3, 16'h0004);
        step(1'b0, 4'b0001, 3'd1, 16'h0000);
        step(1'b0, 4'b0001, 3'd1, 16'h0000); lit("r0_inc_pre_reset", 0, 16'h0001);
        step(1'b1, 4'b0001, 3'd1, 16'h0000); lit("r0_mid_reset", 0, RV);
        chk("wrap_mid_reset", 32'(wrap), 32'h0);
        step(1'b0, 4'b0001, 3'd1, 16'h0000); lit("r0_after_reset", 0, RV + 16'd1);
        reg_sel = 4'b0001; fs = 3'd2; din = 16'h1234; asel = 2'd0;
        #1;
`ifdef REG_BANK_FS_BYPASS_EN
        chk("bypass_load", 32'(out_a), 32'h1234);
`else
        chk("no_bypass_load", 32'(out_a), 32'h0001);
`endif
        reg_sel = 4'd0;
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
